// File: rtl/lab2_dg_display_mux_if.sv
// rtl/lab2_dg_display_mux_if.sv - digit inputs and display pin bundle for the display mux
interface lab2_dg_display_mux_if;
    logic [3:0] s0;
    logic [3:0] s1;
    logic [6:0] seg;
    logic [1:0] an;
    logic       frame;

    modport master (
        output s0,
        output s1,
        input  seg,
        input  an,
        input  frame
    );

    modport slave (
        input  s0,
        input  s1,
        output seg,
        output an,
        output frame
    );
endinterface

// File: rtl/lab2_dg_display_mux.sv
// rtl/lab2_dg_display_mux.sv - two-digit time-multiplexed seven-segment controller
module lab1_dg_segment (
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);
    // Active-low segments, bit order {g,f,e,d,c,b,a}.
    always_comb begin
        seg_o = 7'h7F;
        case (hex_i)
            4'h0: seg_o = 7'h40;
            4'h1: seg_o = 7'h79;
            4'h2: seg_o = 7'h24;
            4'h3: seg_o = 7'h30;
            4'h4: seg_o = 7'h19;
            4'h5: seg_o = 7'h12;
            4'h6: seg_o = 7'h02;
            4'h7: seg_o = 7'h78;
            4'h8: seg_o = 7'h00;
            4'h9: seg_o = 7'h10;
            4'hA: seg_o = 7'h08;
            4'hB: seg_o = 7'h03;
            4'hC: seg_o = 7'h46;
            4'hD: seg_o = 7'h21;
            4'hE: seg_o = 7'h06;
            4'hF: seg_o = 7'h0E;
            default: seg_o = 7'h7F;
        endcase
    end
endmodule

module lab2_dg_display_mux #(
    parameter int DIGIT_CYCLES = 48000,
    parameter int BLANK_CYCLES = 480
) (
    input  logic                  clk,
    input  logic                  reset,
    lab2_dg_display_mux_if.slave  bus
);
    typedef enum logic [1:0] {
        BLANK0 = 2'd0,
        SHOW0  = 2'd1,
        BLANK1 = 2'd2,
        SHOW1  = 2'd3
    } state_t;

    localparam int     MAX_DB    = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int     MAX_N     = (MAX_DB > 2) ? MAX_DB : 2;
    localparam int     CW        = $clog2(MAX_N);
    localparam bit     HAS_BLANK = (BLANK_CYCLES > 0);
    localparam logic [CW-1:0] D_LOAD = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] B_LOAD = CW'(HAS_BLANK ? BLANK_CYCLES - 1 : 0);
    localparam state_t START_STATE = HAS_BLANK ? BLANK0 : SHOW0;
    localparam logic [CW-1:0] START_LOAD = HAS_BLANK ? B_LOAD : D_LOAD;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [6:0]    seg_q, seg_d;
    logic [1:0]    an_q, an_d;
    logic          frame_q, frame_d;
    // Without blanking, reset parks in SHOW0 with digits dark; the first
    // edge then "enters" SHOW0 properly, which live_q tracks.
    logic          live_q, live_d;

    logic [3:0]    dec_in;
    logic [6:0]    dec_seg;

    // Single shared decoder: feed it the digit whose SHOW state is next.
    assign dec_in = ((state_q == BLANK1) || ((state_q == SHOW0) && live_q)) ? bus.s1 : bus.s0;

    lab1_dg_segment u_dec (
        .hex_i (dec_in),
        .seg_o (dec_seg)
    );

    // State, counter and registered display outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= START_STATE;
            cnt_q   <= START_LOAD;
            seg_q   <= 7'h7F;
            an_q    <= 2'b11;
            frame_q <= 1'b0;
            live_q  <= HAS_BLANK;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            frame_q <= frame_d;
            live_q  <= live_d;
        end
    end

    // Next state; outputs are computed for the state being entered so they
    // register on the same edge and the anodes never overlap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q - CW'(1);
        seg_d   = seg_q;
        an_d    = an_q;
        frame_d = 1'b0;
        live_d  = 1'b1;
        if (!live_q) begin
            cnt_d = D_LOAD;
            an_d  = 2'b10;
            seg_d = dec_seg;
        end else if (cnt_q == '0) begin
            case (state_q)
                BLANK0: begin
                    state_d = SHOW0;
                    cnt_d   = D_LOAD;
                    an_d    = 2'b10;
                    seg_d   = dec_seg;
                end
                SHOW0: begin
                    if (HAS_BLANK) begin
                        state_d = BLANK1;
                        cnt_d   = B_LOAD;
                        an_d    = 2'b11;
                        seg_d   = 7'h7F;
                    end else begin
                        state_d = SHOW1;
                        cnt_d   = D_LOAD;
                        an_d    = 2'b01;
                        seg_d   = dec_seg;
                    end
                end
                BLANK1: begin
                    state_d = SHOW1;
                    cnt_d   = D_LOAD;
                    an_d    = 2'b01;
                    seg_d   = dec_seg;
                end
                SHOW1: begin
                    frame_d = 1'b1;
                    if (HAS_BLANK) begin
                        state_d = BLANK0;
                        cnt_d   = B_LOAD;
                        an_d    = 2'b11;
                        seg_d   = 7'h7F;
                    end else begin
                        state_d = SHOW0;
                        cnt_d   = D_LOAD;
                        an_d    = 2'b10;
                        seg_d   = dec_seg;
                    end
                end
                default: begin
                    state_d = START_STATE;
                    cnt_d   = START_LOAD;
                    an_d    = 2'b11;
                    seg_d   = 7'h7F;
                end
            endcase
        end
    end

    assign bus.seg   = seg_q;
    assign bus.an    = an_q;
    assign bus.frame = frame_q;
endmodule
